ppu_layer_fetch: RTL and testbench

//  Scanline tile fetcher downstream of the PPU-facing VRAM half. Per start pulse it reads 64x64 Tile RAM

---
 rtl/ppu_layer_fetch.sv | 171 +++++++++++++++++
 tb/tb_ppu_layer_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_layer_fetch.sv
// ppu_layer_fetch: scanline tile fetcher for one PPU layer (BG or FG).
// On a start pulse it reads Tile RAM and Pattern RAM and writes LB_PIXELS decoded pixels,
// one per cycle, into a scanline line buffer.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   i_start                     1-cycle pulse, sampled only while idle
//   i_layer/i_row/i_scroll_*    fetch parameters, latched at start
//   o_tile_rd/o_tile_addr       Tile RAM request; i_tile_rdata valid the following cycle
//   o_pat_rd/o_pat_addr         Pattern RAM request; i_pat_rdata valid the following cycle
//   o_lb_we/o_lb_addr/o_lb_data line-buffer write port ({palette, color})
//   o_busy, o_done              fetch in progress; 1-cycle completion pulse
//
// Configuration macro: PPU_FETCH_SKIP_TRANSP_EN -- when defined, pixels with color 0 do not
// assert o_lb_we (address and timing are unchanged), so FG can overlay BG in the same buffer.
// Only RD_LATENCY == 1 is supported.
module ppu_layer_fetch #(
  parameter int unsigned LB_PIXELS  = 320,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_layer,
  input  logic [7:0]  i_row,
  input  logic [8:0]  i_scroll_x,
  input  logic [8:0]  i_scroll_y,
  output logic        o_tile_rd,
  output logic [12:0] o_tile_addr,
  input  logic [15:0] i_tile_rdata,
  output logic        o_pat_rd,
  output logic [11:0] o_pat_addr,
  input  logic [63:0] i_pat_rdata,
  output logic        o_lb_we,
  output logic [8:0]  o_lb_addr,
  output logic [7:0]  o_lb_data,
  output logic        o_busy,
  output logic        o_done
);

  if (RD_LATENCY != 1) begin : g_rd_latency_check
    $error("ppu_layer_fetch supports only RD_LATENCY == 1");
  end

  localparam logic [8:0] LastPix = 9'(LB_PIXELS - 1);

  typedef enum logic [2:0] {StIdle, StTRd, StTCap, StPRd, StPCap, StEmit, StFin} state_e;

  state_e      state_q, state_d;
  logic [12:0] tile_addr_q, tile_addr_d;  // {layer, ty, tx}; layer/ty reused for later tiles
  logic [11:0] pat_addr_q, pat_addr_d;
  logic [8:0]  lb_addr_q, lb_addr_d;
  logic [5:0]  tx_q, tx_d;                // column of the next tile to request
  logic [2:0]  fy_q, fy_d;
  logic [2:0]  px_q, px_d;                // pixel slot within the current tile
  logic [3:0]  pal_q, pal_d;
  logic        xflip_q, xflip_d;
  logic        prow_odd_q, prow_odd_d;    // selects upper 32 bits of the pattern word
  logic [31:0] row_q, row_d;

  logic [8:0]  y_start;
  logic [2:0]  prow;
  logic [2:0]  src_px;
  logic [3:0]  color;
  logic        emit;

  assign y_start = {1'b0, i_row} + i_scroll_y;
  // 7 - fy is the bitwise inverse for a 3-bit row index
  assign prow    = i_tile_rdata[1] ? ~fy_q : fy_q;
  assign src_px  = xflip_q ? ~px_q : px_q;
  assign color   = row_q[{src_px, 2'b00} +: 4];
  assign emit    = (state_q == StEmit);

  always_comb begin
    state_d     = state_q;
    tile_addr_d = tile_addr_q;
    pat_addr_d  = pat_addr_q;
    lb_addr_d   = lb_addr_q;
    tx_d        = tx_q;
    fy_d        = fy_q;
    px_d        = px_q;
    pal_d       = pal_q;
    xflip_d     = xflip_q;
    prow_odd_d  = prow_odd_q;
    row_d       = row_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d     = StTRd;
          tile_addr_d = {i_layer, y_start[8:3], i_scroll_x[8:3]};
          tx_d        = i_scroll_x[8:3] + 6'd1;
          fy_d        = y_start[2:0];
          px_d        = i_scroll_x[2:0];  // first tile starts at the fine X offset
          lb_addr_d   = '0;
        end
      end
      StTRd: state_d = StTCap;
      StTCap: begin
        pal_d      = i_tile_rdata[5:2];
        xflip_d    = i_tile_rdata[0];
        prow_odd_d = prow[0];
        pat_addr_d = {i_tile_rdata[15:6], prow[2:1]};
        state_d    = StPRd;
      end
      StPRd: state_d = StPCap;
      StPCap: begin
        row_d   = prow_odd_q ? i_pat_rdata[63:32] : i_pat_rdata[31:0];
        state_d = StEmit;
      end
      StEmit: begin
        px_d = px_q + 3'd1;  // wraps 7 -> 0 for the next tile
        if (lb_addr_q == LastPix) begin
          state_d = StFin;   // may stop mid-tile; address holds at the last pixel
        end else begin
          lb_addr_d = lb_addr_q + 9'd1;
          if (px_q == 3'd7) begin
            state_d     = StTRd;
            tile_addr_d = {tile_addr_q[12:6], tx_q};
            tx_d        = tx_q + 6'd1;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tile_addr_q <= '0;
      pat_addr_q  <= '0;
      lb_addr_q   <= '0;
      tx_q        <= '0;
      fy_q        <= '0;
      px_q        <= '0;
      pal_q       <= '0;
      xflip_q     <= 1'b0;
      prow_odd_q  <= 1'b0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      tile_addr_q <= tile_addr_d;
      pat_addr_q  <= pat_addr_d;
      lb_addr_q   <= lb_addr_d;
      tx_q        <= tx_d;
      fy_q        <= fy_d;
      px_q        <= px_d;
      pal_q       <= pal_d;
      xflip_q     <= xflip_d;
      prow_odd_q  <= prow_odd_d;
      row_q       <= row_d;
    end
  end

  assign o_tile_rd   = (state_q == StTRd);
  assign o_tile_addr = tile_addr_q;
  assign o_pat_rd    = (state_q == StPRd);
  assign o_pat_addr  = pat_addr_q;
  assign o_lb_addr   = lb_addr_q;
  assign o_lb_data   = {pal_q, color};
  assign o_busy      = (state_q != StIdle) && (state_q != StFin);
  assign o_done      = (state_q == StFin);

`ifdef PPU_FETCH_SKIP_TRANSP_EN
  assign o_lb_we = emit && (color != 4'd0);
`else
  assign o_lb_we = emit;
`endif

endmodule

// File: tb/tb_ppu_layer_fetch.sv
// Bench for ppu_layer_fetch: RAM models, write/read monitor, table vectors, corner-case
// sequences and randomized fetches compared against a pixel-level reference model.
module tb_ppu_layer_fetch;

`ifdef PPU_FETCH_SKIP_TRANSP_EN
  localparam bit SkipTransp = 1'b1;
`else
  localparam bit SkipTransp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_layer = 1'b0;
  logic [7:0]  i_row = '0;
  logic [8:0]  i_scroll_x = '0;
  logic [8:0]  i_scroll_y = '0;
  logic        o_tile_rd;
  logic [12:0] o_tile_addr;
  logic [15:0] i_tile_rdata = '0;
  logic        o_pat_rd;
  logic [11:0] o_pat_addr;
  logic [63:0] i_pat_rdata = '0;
  logic        o_lb_we;
  logic [8:0]  o_lb_addr;
  logic [7:0]  o_lb_data;
  logic        o_busy;
  logic        o_done;

  ppu_layer_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_layer     (i_layer),
    .i_row       (i_row),
    .i_scroll_x  (i_scroll_x),
    .i_scroll_y  (i_scroll_y),
    .o_tile_rd   (o_tile_rd),
    .o_tile_addr (o_tile_addr),
    .i_tile_rdata(i_tile_rdata),
    .o_pat_rd    (o_pat_rd),
    .o_pat_addr  (o_pat_addr),
    .i_pat_rdata (i_pat_rdata),
    .o_lb_we     (o_lb_we),
    .o_lb_addr   (o_lb_addr),
    .o_lb_data   (o_lb_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  // RAM models: data valid the cycle after a strobe, garbage otherwise
  logic [15:0] tile_mem [8192];
  logic [63:0] pat_mem  [4096];
  always @(posedge clk) begin
    if (o_tile_rd) i_tile_rdata <= tile_mem[o_tile_addr];
    else           i_tile_rdata <= 16'($urandom);
    if (o_pat_rd)  i_pat_rdata  <= pat_mem[o_pat_addr];
    else           i_pat_rdata  <= {$urandom, $urandom};
  end

  int pos_cnt = 0;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t         got_wr[$], exp_wr[$];
  logic [12:0] got_tile[$], exp_tile[$];
  logic [11:0] got_pat[$], exp_pat[$];
  int          got_done[$];
  int          exp_done;
  bit          busy_log [1024];
  bit          mon_en = 1'b0;
  int          c0 = 0;

  // Cycle 1 is the cycle following the edge that sampled i_start.
  always @(negedge clk) begin
    int cyc;
    if (mon_en) begin
      cyc = pos_cnt - c0 + 1;
      if (o_lb_we)   got_wr.push_back('{addr: o_lb_addr, data: o_lb_data, cyc: cyc});
      if (o_tile_rd) got_tile.push_back(o_tile_addr);
      if (o_pat_rd)  got_pat.push_back(o_pat_addr);
      if (o_done)    got_done.push_back(cyc);
      if (cyc >= 0 && cyc < 1024) busy_log[cyc] = o_busy;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_tile_rd, o_tile_addr, o_pat_rd, o_pat_addr, o_lb_we, o_lb_addr, o_lb_data,
                o_busy, o_done});
  endfunction

  task automatic start_fetch(input logic layer, input logic [7:0] row,
                             input logic [8:0] sx, input logic [8:0] sy);
    @(negedge clk);
    mon_en = 1'b0;
    got_wr.delete(); got_tile.delete(); got_pat.delete(); got_done.delete();
    foreach (busy_log[i]) busy_log[i] = 1'b0;
    i_layer = layer; i_row = row; i_scroll_x = sx; i_scroll_y = sy;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    c0 = pos_cnt;
    mon_en = 1'b1;
    i_start = 1'b0;
  endtask

  task automatic wait_cycle(input int n);
    while (pos_cnt - c0 + 1 < n) @(negedge clk);
  endtask

  task automatic pulse_start_at(input int n);
    wait_cycle(n);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (got_done.size() == 0 && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(got_done.size() != 0), 64'd1);
    repeat (5) @(negedge clk);
  endtask

  // Pixel-level model: screen pixel n lives at layer X = scroll_x + n.
  task automatic build_model(input logic layer, input logic [7:0] row,
                             input logic [8:0] sx, input logic [8:0] sy);
    int y, fy, ty, fx, ntiles, k, p, prow, src;
    logic [12:0] ta;
    logic [15:0] w;
    logic [63:0] pr;
    logic [3:0]  col;
    exp_wr.delete(); exp_tile.delete(); exp_pat.delete();
    y  = (int'(row) + int'(sy)) % 512;
    fy = y % 8;
    ty = y / 8;
    fx = int'(sx) % 8;
    ntiles = (fx + 319) / 8 + 1;
    for (int kk = 0; kk < ntiles; kk++) begin
      ta   = {layer, 6'(ty), 6'((int'(sx) / 8 + kk) % 64)};
      w    = tile_mem[ta];
      prow = w[1] ? 7 - fy : fy;
      exp_tile.push_back(ta);
      exp_pat.push_back({w[15:6], 2'(prow / 2)});
    end
    for (int n = 0; n < 320; n++) begin
      k    = (fx + n) / 8;
      p    = (fx + n) % 8;
      w    = tile_mem[exp_tile[k]];
      prow = w[1] ? 7 - fy : fy;
      pr   = pat_mem[{w[15:6], 2'(prow / 2)}];
      if (prow % 2 == 1) pr = pr >> 32;
      src  = w[0] ? 7 - p : p;
      col  = 4'(pr >> (4 * src));
      if (!(SkipTransp && col == 4'd0))
        exp_wr.push_back('{addr: 9'(n), data: {w[5:2], col}, cyc: 5 + n + 4 * k});
    end
    exp_done = 5 + 319 + 4 * ((fx + 319) / 8) + 1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      chk($sformatf("%s_wr%0d{addr,data,cyc}", tag, i),
          64'({got_wr[i].addr, got_wr[i].data, 16'(got_wr[i].cyc)}),
          64'({exp_wr[i].addr, exp_wr[i].data, 16'(exp_wr[i].cyc)}));
    chk({tag, "_ntile"}, 64'(got_tile.size()), 64'(exp_tile.size()));
    for (int i = 0; i < got_tile.size() && i < exp_tile.size(); i++)
      chk($sformatf("%s_tile_addr%0d", tag, i), 64'(got_tile[i]), 64'(exp_tile[i]));
    chk({tag, "_npat"}, 64'(got_pat.size()), 64'(exp_pat.size()));
    for (int i = 0; i < got_pat.size() && i < exp_pat.size(); i++)
      chk($sformatf("%s_pat_addr%0d", tag, i), 64'(got_pat[i]), 64'(exp_pat[i]));
    chk({tag, "_ndone"}, 64'(got_done.size()), 64'd1);
    if (got_done.size() > 0) chk({tag, "_done_cyc"}, 64'(got_done[0]), 64'(exp_done));
  endtask

  task automatic fill_plain_mem();
    foreach (tile_mem[i]) tile_mem[i] = {10'(i), 4'd5, 2'b00};
    foreach (pat_mem[i])  pat_mem[i]  = {32'h76543210, 32'h76543210};
  endtask

  typedef struct {
    logic        layer;
    logic [7:0]  row;
    logic [8:0]  sx;
    logic [8:0]  sy;
    logic [12:0] tile0;
    logic [1:0]  pat_lo0;
    int          ntile;
    logic [7:0]  data0;
    int          done_cyc;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cnt;
    vecs[0] = '{1'b0, 8'd0,   9'd0,   9'd0,   13'd0,    2'd0, 40, 8'h50, 481};
    vecs[1] = '{1'b0, 8'd0,   9'd3,   9'd0,   13'd0,    2'd0, 41, 8'h53, 485};
    vecs[2] = '{1'b0, 8'd0,   9'd509, 9'd0,   13'd63,   2'd0, 41, 8'h55, 485};
    vecs[3] = '{1'b1, 8'd239, 9'd0,   9'd300, 13'h10C0, 2'd1, 40, 8'h50, 481};
    fill_plain_mem();

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      start_fetch(vecs[v].layer, vecs[v].row, vecs[v].sx, vecs[v].sy);
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_ntile", v), 64'(got_tile.size()), 64'(vecs[v].ntile));
      if (got_tile.size() > 0)
        chk($sformatf("vec%0d_tile0", v), 64'(got_tile[0]), 64'(vecs[v].tile0));
      if (got_pat.size() > 0)
        chk($sformatf("vec%0d_pat_lo0", v), 64'(got_pat[0][1:0]), 64'(vecs[v].pat_lo0));
      if (got_done.size() > 0)
        chk($sformatf("vec%0d_done_cyc", v), 64'(got_done[0]), 64'(vecs[v].done_cyc));
`ifndef PPU_FETCH_SKIP_TRANSP_EN
      if (got_wr.size() > 0)
        chk($sformatf("vec%0d_first_wr", v), 64'({got_wr[0].addr, got_wr[0].data}),
            64'({9'd0, vecs[v].data0}));
`endif
      build_model(vecs[v].layer, vecs[v].row, vecs[v].sx, vecs[v].sy);
      compare_all($sformatf("vec%0d", v));
    end

    // X flip on tile (0,0): colors 7..0 at addresses 0..7
    tile_mem[0] = {10'd0, 4'd5, 2'b01};
    start_fetch(1'b0, 8'd0, 9'd0, 9'd0);
    wait_done("xflip");
    for (int i = 0; i < 8; i++)
      if (got_wr.size() > i)
        chk($sformatf("xflip_px%0d", i), 64'({got_wr[i].addr, got_wr[i].data}),
            64'({9'(i), 4'd5, 4'(7 - i)}));
    build_model(1'b0, 8'd0, 9'd0, 9'd0);
    compare_all("xflip");

    // Y flip with fy=0 reads pattern row 7 from the upper half
    tile_mem[0] = {10'd0, 4'd5, 2'b10};
    pat_mem[3]  = {32'hFEDCBA98, 32'h76543210};
    start_fetch(1'b0, 8'd0, 9'd0, 9'd0);
    wait_done("yflip");
    if (got_pat.size() > 0) chk("yflip_pat_addr0", 64'(got_pat[0]), 64'd3);
    if (got_wr.size() > 0) chk("yflip_px0", 64'(got_wr[0].data), 64'h58);
    build_model(1'b0, 8'd0, 9'd0, 9'd0);
    compare_all("yflip");
    fill_plain_mem();

    // Starts while busy and on the done cycle are ignored
    start_fetch(1'b0, 8'd0, 9'd0, 9'd0);
    pulse_start_at(10);
    pulse_start_at(481);
    wait_cycle(500);
    chk("busy_c1", 64'(busy_log[1]), 64'd1);
    chk("busy_c480", 64'(busy_log[480]), 64'd1);
    chk("busy_c481", 64'(busy_log[481]), 64'd0);
    chk("busy_c482", 64'(busy_log[482]), 64'd0);
    build_model(1'b0, 8'd0, 9'd0, 9'd0);
    compare_all("ignore_start");

    // Reset mid-fetch aborts immediately
    start_fetch(1'b0, 8'd0, 9'd0, 9'd0);
    wait_cycle(50);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_outputs_c51", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    cnt = 0;
    foreach (got_wr[i]) if (got_wr[i].cyc >= 51) cnt++;
    chk("rst_no_wr_after", 64'(cnt), 64'd0);
    chk("rst_wr_before", 64'(got_wr.size()), SkipTransp ? 64'd28 : 64'd32);
    chk("rst_no_done", 64'(got_done.size()), 64'd0);
    chk("rst_ntile", 64'(got_tile.size()), 64'd5);

`ifdef PPU_FETCH_SKIP_TRANSP_EN
    foreach (pat_mem[i]) pat_mem[i] = {32'h00000F0F, 32'h00000F0F};
    start_fetch(1'b0, 8'd0, 9'd0, 9'd0);
    wait_done("transp");
    chk("transp_nwr", 64'(got_wr.size()), 64'd80);
    if (got_wr.size() > 1) chk("transp_wr1_addr", 64'(got_wr[1].addr), 64'd2);
    if (got_done.size() > 0) chk("transp_done_cyc", 64'(got_done[0]), 64'd481);
    build_model(1'b0, 8'd0, 9'd0, 9'd0);
    compare_all("transp");
`endif

    for (int r = 0; r < 10; r++) begin
      logic        lay;
      logic [7:0]  row;
      logic [8:0]  sx, sy;
      foreach (tile_mem[i]) tile_mem[i] = 16'($urandom);
      foreach (pat_mem[i])  pat_mem[i]  = {$urandom, $urandom};
      lay = 1'($urandom);
      row = 8'($urandom_range(239, 0));
      sx  = 9'($urandom);
      sy  = 9'($urandom);
      start_fetch(lay, row, sx, sy);
      wait_done($sformatf("rnd%0d", r));
      build_model(lay, row, sx, sy);
      compare_all($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
